// File: rtl/mux_4x1_rr_sched_if.sv
// Bus between the four requesters, the round-robin scheduler and the downstream sink.
// The scheduler sits on the slave modport and the environment on the master modport.
interface mux_4x1_rr_sched_if;
    logic [3:0] req;
    logic [3:0] in;
    logic       out_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_data;

    modport master (
        output req,
        output in,
        output out_ready,
        input  grant,
        input  sel,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  req,
        input  in,
        input  out_ready,
        output grant,
        output sel,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mux_4x1_rr_sched.sv
// Round-robin scheduler driving a 4:1 bit multiplexer.
// Each grant lasts until its requester drops req or MAX_BURST transfers complete.
module mux_4x1_rr_sched #(
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mux_4x1_rr_sched_if.slave        bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t     state_reg;
    logic [1:0] sel_reg;
    logic [1:0] ptr_reg;
    logic [3:0] grant_reg;
    logic [3:0] cnt_reg;

    logic       out_valid;
    logic       xfer;
    logic       release_now;
    logic [1:0] arb_ptr;
    logic [3:0] arb_mask;
    logic       arb_found;
    logic [1:0] arb_idx;
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;

    always_comb begin
        out_valid   = (state_reg == GRANT) && bus.req[sel_reg];
        xfer        = out_valid && bus.out_ready;
        release_now = (state_reg == GRANT) &&
                      (!bus.req[sel_reg] || (xfer && (cnt_reg == CNT_LAST)));
        // On release, search starts after the current owner and skips its request.
        arb_ptr     = (state_reg == GRANT) ? sel_reg + 2'd1 : ptr_reg;
        arb_mask    = (state_reg == GRANT) ? (bus.req & ~grant_reg) : bus.req;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = arb_ptr + 2'(gi);
            assign cand_hit[gi] = arb_mask[cand_idx[gi]];
        end
    endgenerate

    // Lowest rotated position wins, so scan from the far end downwards.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = arb_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (cand_hit[i]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            ptr_reg   <= 2'd0;
            grant_reg <= 4'd0;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_found) begin
                        state_reg <= GRANT;
                        sel_reg   <= arb_idx;
                        grant_reg <= 4'b0001 << arb_idx;
                        cnt_reg   <= 4'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_reg <= sel_reg + 2'd1;
                        if (arb_found) begin
                            sel_reg   <= arb_idx;
                            grant_reg <= 4'b0001 << arb_idx;
                            cnt_reg   <= 4'd0;
                        end else begin
                            state_reg <= IDLE;
                            grant_reg <= 4'd0;
                        end
                    end else if (xfer) begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.sel       = sel_reg;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = bus.in[sel_reg];
endmodule

// File: tb/tb_mux_4x1_rr_sched.sv
// Directed bench for the round-robin 4:1 scheduler with hand-computed expectations.
module tb_mux_4x1_rr_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [3:0] in_pat;
    int   e;

    mux_4x1_rr_sched_if bus_if ();

    mux_4x1_rr_sched #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_grant", bus_if.grant, 4'b0000);
        check("rst_valid", {3'b0, bus_if.out_valid}, 4'd0);
        check("rst_sel", {2'b0, bus_if.sel}, 4'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus_if.req = 4'b0000;
        bus_if.in = 4'b0000;
        bus_if.out_ready = 1'b0;

        // Two requesters, full bursts, wrap back to the first.
        bus_if.req = 4'b1010;
        bus_if.in = 4'b0110;
        bus_if.out_ready = 1'b1;
        do_reset();
        tick();
        check("a_grant1", bus_if.grant, 4'b0010);
        check("a_sel1", {2'b0, bus_if.sel}, 4'd1);
        check("a_data1", {3'b0, bus_if.out_data}, 4'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("a_hold1", bus_if.grant, 4'b0010);
        end
        tick();
        check("a_grant3", bus_if.grant, 4'b1000);
        check("a_sel3", {2'b0, bus_if.sel}, 4'd3);
        check("a_data3", {3'b0, bus_if.out_data}, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("a_hold3", bus_if.grant, 4'b1000);
        end
        tick();
        check("a_wrap", bus_if.grant, 4'b0010);

        // All four requesting: 4-cycle grants in rotation, no gaps.
        bus_if.req = 4'b1111;
        in_pat = 4'b0101;
        bus_if.in = in_pat;
        do_reset();
        tick();
        for (int k = 0; k < 20; k++) begin
            e = (k / 4) % 4;
            $display("cycle %0d grant=%b sel=%0d out_data=%b", k, bus_if.grant, bus_if.sel, bus_if.out_data);
            check("b_grant", bus_if.grant, 4'b0001 << e);
            check("b_valid", {3'b0, bus_if.out_valid}, 4'd1);
            check("b_data", {3'b0, bus_if.out_data}, {3'b0, in_pat[e]});
            if (k == 9) begin
                in_pat = 4'b1010;
                bus_if.in = in_pat;
                #1;
                check("b_data_chg", {3'b0, bus_if.out_data}, {3'b0, in_pat[e]});
            end
            tick();
        end

        // Back-pressure on sel=2, then the ready burst, then a mid-burst drop on sel=0.
        bus_if.req = 4'b0100;
        bus_if.out_ready = 1'b0;
        do_reset();
        tick();
        bus_if.req = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            check("c_stall_grant", bus_if.grant, 4'b0100);
            check("c_stall_valid", {3'b0, bus_if.out_valid}, 4'd1);
            check("c_stall_cnt", dut.cnt_reg, 4'd0);
            tick();
        end
        bus_if.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("c_cnt", dut.cnt_reg, 4'(i));
        end
        tick();
        check("c_next_grant", bus_if.grant, 4'b0001);
        check("c_ptr", {2'b0, dut.ptr_reg}, 4'd3);
        tick();
        tick();
        check("c_cnt2", dut.cnt_reg, 4'd2);
        bus_if.req = 4'b0110;
        #1;
        check("c_drop_valid", {3'b0, bus_if.out_valid}, 4'd0);
        check("c_drop_grant", bus_if.grant, 4'b0001);
        tick();
        check("c_after_grant", bus_if.grant, 4'b0010);
        check("c_after_sel", {2'b0, bus_if.sel}, 4'd1);
        check("c_after_ptr", {2'b0, dut.ptr_reg}, 4'd1);
        check("c_after_cnt", dut.cnt_reg, 4'd0);

        // Asynchronous reset in the middle of a burst on sel=3.
        bus_if.req = 4'b1000;
        bus_if.out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        check("d_sel", {2'b0, bus_if.sel}, 4'd3);
        check("d_cnt", dut.cnt_reg, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("d_async_grant", bus_if.grant, 4'b0000);
        check("d_async_sel", {2'b0, bus_if.sel}, 4'd0);
        check("d_async_valid", {3'b0, bus_if.out_valid}, 4'd0);
        check("d_async_cnt", dut.cnt_reg, 4'd0);
        tick();
        rst_n = 1'b1;
        check("d_held_grant", bus_if.grant, 4'b0000);
        tick();
        check("d_regrant", bus_if.grant, 4'b1000);
        check("d_regrant_cnt", dut.cnt_reg, 4'd0);
        tick();
        check("d_cnt_fresh", dut.cnt_reg, 4'd1);

        // Lone requester: full burst, one idle cycle, then granted again.
        bus_if.req = 4'b0001;
        do_reset();
        tick();
        check("e_grant", bus_if.grant, 4'b0001);
        tick();
        tick();
        tick();
        check("e_last", bus_if.grant, 4'b0001);
        tick();
        check("e_idle_grant", bus_if.grant, 4'b0000);
        check("e_idle_valid", {3'b0, bus_if.out_valid}, 4'd0);
        tick();
        check("e_regrant", bus_if.grant, 4'b0001);
        check("e_regrant_cnt", dut.cnt_reg, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
